// File: rtl/combo_lock_pkg.sv
// combo_lock_pkg: shared definitions for the combination-lock controller.
//   - state_e          : controller states (ENTRY, CHECK, OPEN, FAIL, LOCKOUT)
//   - *_DEFAULT        : default parameter values for combo_lock_ctrl
//   - TIMER_W          : width of the shared FAIL/LOCKOUT down-counter
//   - DISP_FAIL/LOCK   : nibble shown on every digit in FAIL / LOCKOUT
//   - sel_onehot()     : decimal-point marker for the digit being edited
package combo_lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  localparam logic [15:0] COMBO_DEFAULT     = 16'h1234;
  localparam int          MAX_FAIL_DEFAULT  = 3;
  localparam int          FAIL_HOLD_DEFAULT = 100_000_000;
  localparam int          LOCKOUT_DEFAULT   = 1_000_000_000;

  // 2^30 > 1_000_000_000, so one 30-bit counter covers both hold times.
  localparam int          TIMER_W = 30;

  localparam logic [3:0]  DISP_FAIL = 4'hE;
  localparam logic [3:0]  DISP_LOCK = 4'hF;

  // Slot 0 is the leftmost digit (disp3), so its marker is the MSB.
  function automatic logic [3:0] sel_onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter used to time the FAIL and LOCKOUT holds.
//   clk, rst_n   : clock, asynchronous active-low reset (count forced to 0)
//   load_i       : load load_val_i this cycle (wins over en_i)
//   load_val_i   : value to load, i.e. hold length minus one
//   en_i         : count down by one, stopping at zero
//   done_o       : count is zero
module cycle_timer
  import combo_lock_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: four-digit combination lock with fail hold and lockout.
//   clk, rst_n            : clock, asynchronous active-low reset
//   incP/decP             : step the digit being edited up/down (mod 16)
//   enterP                : commit the digit; the fourth commit checks the code
//   clearP                : abort entry, or relock from OPEN
//   disp3..disp0          : nibbles for the display (disp3 = first digit)
//   digitSel              : one-hot marker of the digit being edited
//   unlocked/error/lockout: high in OPEN / FAIL / LOCKOUT
//   dbg_state/dbg_fail_cnt: current state and consecutive-failure count
//
// Inputs are debounced single-cycle pulses with no back-pressure: a pulse is
// acted on in the cycle it is high, or dropped if the current state ignores it.
// All outputs are registered from next-state values, so they change on the
// same edge as the state register (one cycle after the input pulse).
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter logic [15:0] COMBO            = COMBO_DEFAULT,
  parameter int          MAX_FAIL         = MAX_FAIL_DEFAULT,
  parameter int          FAIL_HOLD_CYCLES = FAIL_HOLD_DEFAULT,
  parameter int          LOCKOUT_CYCLES   = LOCKOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       incP,
  input  logic       decP,
  input  logic       enterP,
  input  logic       clearP,
  output logic [3:0] disp3,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [3:0] disp0,
  output logic [3:0] digitSel,
  output logic       unlocked,
  output logic       error,
  output logic       lockout,
  output state_e     dbg_state,
  output logic [2:0] dbg_fail_cnt
);

  state_e             state_q, state_d;
  logic [3:0][3:0]    slot_q, slot_d;      // slot 0 = first digit entered
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         cur_q, cur_d;
  logic [2:0]         fail_cnt_q, fail_cnt_d;

  logic [3:0][3:0]    disp_q, disp_d;      // index 0 drives disp3
  logic [3:0]         sel_q, sel_d;
  logic               unlocked_q, unlocked_d;
  logic               error_q, error_d;
  logic               lockout_q, lockout_d;

  logic               tmr_load, tmr_en, tmr_done;
  logic [TIMER_W-1:0] tmr_load_val;

  cycle_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  // Next-state and datapath.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    idx_d        = idx_q;
    cur_d        = cur_q;
    fail_cnt_d   = fail_cnt_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (clearP) begin
          slot_d = '0;
          idx_d  = '0;
          cur_d  = '0;
        end else if (enterP) begin
          slot_d[idx_q] = cur_q;
          cur_d         = '0;
          idx_d         = idx_q + 2'd1;   // wraps to 0 after the fourth digit
          if (idx_q == 2'd3) begin
            state_d = ST_CHECK;
          end
        end else if (incP && !decP) begin
          cur_d = cur_q + 4'd1;
        end else if (decP && !incP) begin
          cur_d = cur_q - 4'd1;
        end
      end

      ST_CHECK: begin
        if ({slot_q[0], slot_q[1], slot_q[2], slot_q[3]} == COMBO) begin
          state_d    = ST_OPEN;
          fail_cnt_d = '0;
        end else begin
          fail_cnt_d = (fail_cnt_q == 3'd7) ? fail_cnt_q : fail_cnt_q + 3'd1;
          tmr_load   = 1'b1;
          // Timer counts load value down to 0 inclusive, hence the minus one.
          if (fail_cnt_d == 3'(MAX_FAIL)) begin
            state_d      = ST_LOCKOUT;
            tmr_load_val = TIMER_W'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d      = ST_FAIL;
            tmr_load_val = TIMER_W'(FAIL_HOLD_CYCLES - 1);
          end
        end
      end

      ST_OPEN: begin
        if (clearP) begin
          state_d = ST_ENTRY;
          slot_d  = '0;
          idx_d   = '0;
          cur_d   = '0;
        end
      end

      ST_FAIL, ST_LOCKOUT: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          state_d = ST_ENTRY;
          slot_d  = '0;
          idx_d   = '0;
          cur_d   = '0;
          if (state_q == ST_LOCKOUT) begin
            fail_cnt_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_ENTRY;
      end
    endcase
  end

  // Output decode from next-state values, registered below.
  always_comb begin
    disp_d     = '0;
    sel_d      = '0;
    unlocked_d = 1'b0;
    error_d    = 1'b0;
    lockout_d  = 1'b0;

    case (state_d)
      ST_ENTRY: begin
        for (int i = 0; i < 4; i++) begin
          if (2'(i) < idx_d) begin
            disp_d[i] = slot_d[i];
          end else if (2'(i) == idx_d) begin
            disp_d[i] = cur_d;
          end
        end
        sel_d = sel_onehot(idx_d);
      end
      ST_CHECK: begin
        disp_d = slot_d;
      end
      ST_OPEN: begin
        disp_d     = slot_d;
        unlocked_d = 1'b1;
      end
      ST_FAIL: begin
        disp_d  = {4{DISP_FAIL}};
        error_d = 1'b1;
      end
      ST_LOCKOUT: begin
        disp_d    = {4{DISP_LOCK}};
        lockout_d = 1'b1;
      end
      default: begin
        disp_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ENTRY;
      slot_q     <= '0;
      idx_q      <= '0;
      cur_q      <= '0;
      fail_cnt_q <= '0;
      disp_q     <= '0;
      sel_q      <= 4'b1000;
      unlocked_q <= 1'b0;
      error_q    <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      cur_q      <= cur_d;
      fail_cnt_q <= fail_cnt_d;
      disp_q     <= disp_d;
      sel_q      <= sel_d;
      unlocked_q <= unlocked_d;
      error_q    <= error_d;
      lockout_q  <= lockout_d;
    end
  end

  assign disp3        = disp_q[0];
  assign disp2        = disp_q[1];
  assign disp1        = disp_q[2];
  assign disp0        = disp_q[3];
  assign digitSel     = sel_q;
  assign unlocked     = unlocked_q;
  assign error        = error_q;
  assign lockout      = lockout_q;
  assign dbg_state    = state_q;
  assign dbg_fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
module tb_combo_lock_ctrl;
  import combo_lock_pkg::*;

  localparam logic [15:0] COMBO    = 16'h1234;
  localparam int          MAX_FAIL = 3;
  localparam int          HOLD     = 4;
  localparam int          LOCK     = 8;

  localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_FAIL = 3, M_LOCK = 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       incP = 1'b0, decP = 1'b0, enterP = 1'b0, clearP = 1'b0;
  logic [3:0] disp3, disp2, disp1, disp0, digitSel;
  logic       unlocked, error, lockout;
  state_e     dbg_state;
  logic [2:0] dbg_fail_cnt;

  always #5 clk = ~clk;

  combo_lock_ctrl #(
    .COMBO            (COMBO),
    .MAX_FAIL         (MAX_FAIL),
    .FAIL_HOLD_CYCLES (HOLD),
    .LOCKOUT_CYCLES   (LOCK)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .incP         (incP),
    .decP         (decP),
    .enterP       (enterP),
    .clearP       (clearP),
    .disp3        (disp3),
    .disp2        (disp2),
    .disp1        (disp1),
    .disp0        (disp0),
    .digitSel     (digitSel),
    .unlocked     (unlocked),
    .error        (error),
    .lockout      (lockout),
    .dbg_state    (dbg_state),
    .dbg_fail_cnt (dbg_fail_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  int         m_mode, m_cur, m_fails, m_left;
  logic [3:0] ent[$];

  task automatic model_reset();
    m_mode = M_ENTRY; m_cur = 0; m_fails = 0; m_left = 0;
    ent.delete();
  endtask

  task automatic model_step(input logic i, input logic d, input logic e, input logic c);
    int code;
    case (m_mode)
      M_ENTRY: begin
        if (c) begin
          ent.delete(); m_cur = 0;
        end else if (e) begin
          ent.push_back(4'(m_cur)); m_cur = 0;
          if (ent.size() == 4) m_mode = M_CHECK;
        end else if (i && !d) begin
          m_cur = (m_cur + 1) % 16;
        end else if (d && !i) begin
          m_cur = (m_cur + 15) % 16;
        end
      end
      M_CHECK: begin
        code = ent[0] * 4096 + ent[1] * 256 + ent[2] * 16 + ent[3];
        if (code == int'(COMBO)) begin
          m_mode = M_OPEN; m_fails = 0;
        end else begin
          m_fails = (m_fails < 7) ? m_fails + 1 : 7;
          if (m_fails == MAX_FAIL) begin m_mode = M_LOCK; m_left = LOCK; end
          else                     begin m_mode = M_FAIL; m_left = HOLD; end
        end
      end
      M_OPEN: begin
        if (c) begin m_mode = M_ENTRY; ent.delete(); m_cur = 0; end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          if (m_mode == M_LOCK) m_fails = 0;
          m_mode = M_ENTRY; ent.delete(); m_cur = 0;
        end
      end
    endcase
  endtask

  // {disp3, disp2, disp1, disp0, digitSel, unlocked, error, lockout}
  function automatic logic [22:0] exp_vec();
    logic [3:0] d [4];
    logic [3:0] sel;
    logic u, e, l;
    for (int k = 0; k < 4; k++) d[k] = 4'h0;
    sel = 4'b0; u = 1'b0; e = 1'b0; l = 1'b0;
    case (m_mode)
      M_ENTRY: begin
        for (int k = 0; k < 4; k++) begin
          if (k < ent.size())       d[k] = ent[k];
          else if (k == ent.size()) d[k] = 4'(m_cur);
        end
        sel = 4'(8 >> ent.size());
      end
      M_CHECK, M_OPEN: begin
        for (int k = 0; k < 4; k++) d[k] = ent[k];
        u = (m_mode == M_OPEN);
      end
      M_FAIL: begin
        for (int k = 0; k < 4; k++) d[k] = 4'hE;
        e = 1'b1;
      end
      default: begin
        for (int k = 0; k < 4; k++) d[k] = 4'hF;
        l = 1'b1;
      end
    endcase
    return {d[0], d[1], d[2], d[3], sel, u, e, l};
  endfunction

  function automatic logic [22:0] obs_vec();
    return {disp3, disp2, disp1, disp0, digitSel, unlocked, error, lockout};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic i, input logic d, input logic e, input logic c);
    @(negedge clk);
    incP = i; decP = d; enterP = e; clearP = c;
    @(posedge clk);
    model_step(i, d, e, c);
    #1;
    incP = 1'b0; decP = 1'b0; enterP = 1'b0; clearP = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Clears, then dials each digit (dec for high values) and commits it.
  task automatic enter_code(input logic [15:0] code);
    logic [15:0] c;
    logic [3:0]  v;
    c = code;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int p = 0; p < 4; p++) begin
      v = c[15 - 4 * p -: 4];
      if (v > 4'd8) repeat (16 - int'(v)) drive(1'b0, 1'b1, 1'b0, 1'b0);
      else          repeat (int'(v))      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs_vec() !== {16'h0000, 4'b1000, 3'b000})
      $display("FAIL reset_outputs: got %h expected %h", obs_vec(), {16'h0000, 4'b1000, 3'b000});
    else n_pass++;
    n_checks++;
    if (dbg_state !== ST_ENTRY || dbg_fail_cnt !== 3'd0)
      $display("FAIL reset_state: got state %0d cnt %0d expected state %0d cnt 0", dbg_state, dbg_fail_cnt, ST_ENTRY);
    else n_pass++;
    rst_n = 1'b1;
    idle(1);
    n_checks++;
    if (obs_vec() !== exp_vec())
      $display("FAIL reset_release: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_open();
    enter_code(COMBO);
    n_checks++;
    if (obs_vec() !== {16'h1234, 4'b0000, 3'b000} || dbg_state !== ST_CHECK)
      $display("FAIL open_check_cycle: got %h state %0d expected %h state %0d",
               obs_vec(), dbg_state, {16'h1234, 4'b0000, 3'b000}, ST_CHECK);
    else n_pass++;
    idle(1);
    n_checks++;
    if (obs_vec() !== {16'h1234, 4'b0000, 3'b100} || dbg_fail_cnt !== 3'd0)
      $display("FAIL open_unlocked: got %h cnt %0d expected %h cnt 0", obs_vec(), dbg_fail_cnt, {16'h1234, 4'b0000, 3'b100});
    else n_pass++;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs_vec() !== {16'h1234, 4'b0000, 3'b100})
      $display("FAIL open_ignores_pulses: got %h expected %h", obs_vec(), {16'h1234, 4'b0000, 3'b100});
    else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs_vec() !== {16'h0000, 4'b1000, 3'b000} || obs_vec() !== exp_vec())
      $display("FAIL open_relock: got %h expected %h", obs_vec(), {16'h0000, 4'b1000, 3'b000});
    else n_pass++;
  endtask

  task automatic test_digit_edit();
    logic [3:0]  st [8];
    logic [22:0] ex [8];
    // stimulus {inc, dec, enter, clear} with the required outputs after it
    st = '{4'b0100, 4'b1000, 4'b1100, 4'b1000, 4'b0010, 4'b0100, 4'b1010, 4'b0011};
    ex = '{{16'hF000, 4'b1000, 3'b000}, {16'h0000, 4'b1000, 3'b000},
           {16'h0000, 4'b1000, 3'b000}, {16'h1000, 4'b1000, 3'b000},
           {16'h1000, 4'b0100, 3'b000}, {16'h1F00, 4'b0100, 3'b000},
           {16'h1F00, 4'b0010, 3'b000}, {16'h0000, 4'b1000, 3'b000}};
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      drive(st[k][3], st[k][2], st[k][1], st[k][0]);
      n_checks++;
      if (obs_vec() !== ex[k] || obs_vec() !== exp_vec())
        $display("FAIL digit_edit_step%0d: got %h expected %h", k, obs_vec(), ex[k]);
      else n_pass++;
    end
  endtask

  task automatic test_fail();
    int err_cycles;
    do_reset();
    enter_code(16'h1235);
    n_checks++;
    if (obs_vec() !== {16'h1235, 4'b0000, 3'b000})
      $display("FAIL fail_check_cycle: got %h expected %h", obs_vec(), {16'h1235, 4'b0000, 3'b000});
    else n_pass++;
    err_cycles = 0;
    for (int k = 0; k < HOLD + 1; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (error) err_cycles++;
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL fail_hold_cycle%0d: got %h expected %h", k, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (err_cycles != HOLD || obs_vec() !== {16'h0000, 4'b1000, 3'b000} || dbg_fail_cnt !== 3'd1)
      $display("FAIL fail_duration: got %0d cycles out %h cnt %0d expected %0d cycles out %h cnt 1",
               err_cycles, obs_vec(), dbg_fail_cnt, HOLD, {16'h0000, 4'b1000, 3'b000});
    else n_pass++;
  endtask

  task automatic test_lockout();
    int lock_cycles;
    do_reset();
    enter_code(16'h4321); idle(HOLD + 1);
    enter_code(16'hABCD); idle(HOLD + 1);
    n_checks++;
    if (dbg_fail_cnt !== 3'd2)
      $display("FAIL lockout_two_fails: got %0d expected 2", dbg_fail_cnt);
    else n_pass++;
    enter_code(16'h0000);
    lock_cycles = 0;
    for (int k = 0; k < LOCK + 1; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      if (lockout) lock_cycles++;
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL lockout_cycle%0d: got %h expected %h", k, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (lock_cycles != LOCK || obs_vec() !== {16'h0000, 4'b1000, 3'b000} || dbg_fail_cnt !== 3'd0)
      $display("FAIL lockout_duration: got %0d cycles out %h cnt %0d expected %0d cycles out %h cnt 0",
               lock_cycles, obs_vec(), dbg_fail_cnt, LOCK, {16'h0000, 4'b1000, 3'b000});
    else n_pass++;
  endtask

  task automatic test_recover();
    do_reset();
    enter_code(16'h1111); idle(HOLD + 1);
    enter_code(16'h2222); idle(HOLD + 1);
    enter_code(COMBO);
    idle(1);
    n_checks++;
    if (obs_vec() !== {16'h1234, 4'b0000, 3'b100} || dbg_fail_cnt !== 3'd0)
      $display("FAIL recover_open: got %h cnt %0d expected %h cnt 0", obs_vec(), dbg_fail_cnt, {16'h1234, 4'b0000, 3'b100});
    else n_pass++;
  endtask

  task automatic test_reset_mid_lockout();
    do_reset();
    enter_code(16'h9999); idle(HOLD + 1);
    enter_code(16'h8888); idle(HOLD + 1);
    enter_code(16'h7777);
    idle(3);
    n_checks++;
    if (lockout !== 1'b1)
      $display("FAIL midlock_in_lockout: got %b expected 1", lockout);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== {16'h0000, 4'b1000, 3'b000} || dbg_state !== ST_ENTRY || dbg_fail_cnt !== 3'd0)
      $display("FAIL midlock_async_reset: got %h state %0d cnt %0d expected %h state %0d cnt 0",
               obs_vec(), dbg_state, dbg_fail_cnt, {16'h0000, 4'b1000, 3'b000}, ST_ENTRY);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(LOCK + 2);
    n_checks++;
    if (obs_vec() !== {16'h0000, 4'b1000, 3'b000} || obs_vec() !== exp_vec())
      $display("FAIL midlock_after_release: got %h expected %h", obs_vec(), {16'h0000, 4'b1000, 3'b000});
    else n_pass++;
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int round = 0; round < 12; round++) begin
      r = int'($urandom_range(0, 2));
      if (r == 0)      enter_code(COMBO);
      else if (r == 1) enter_code(16'($urandom));
      for (int k = 0; k < 25; k++) begin
        drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0);
        n_checks++;
        if (obs_vec() !== exp_vec() || int'(dbg_fail_cnt) != m_fails)
          $display("FAIL random_r%0d_c%0d: got %h cnt %0d expected %h cnt %0d",
                   round, k, obs_vec(), dbg_fail_cnt, exp_vec(), m_fails);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_digit_edit();
    test_fail();
    test_lockout();
    test_recover();
    test_reset_mid_lockout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
